cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameters: DATA_W, default 32, result data width; TAG_W, default 4, ROB tag width, where tag 0 means "no tag"; DEPTH, default 2, per-requester FIFO depth.
REQ-002 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  synchronous, active-low reset.
REQ-004 ena  input  1  global enable; when low, the block SHALL stall.
REQ-005 rollback  input  1  pipeline flush request from the ROB.
REQ-006 alu_valid, lsb_valid, bru_valid  input  1 each  result offered by the ALU, load/store buffer or branch unit.
REQ-007 alu_tag, lsb_tag, bru_tag  input  TAG_W each  destination ROB tag of the offered result.
REQ-008 alu_data, lsb_data, bru_data  input  DATA_W each  result value.
REQ-009 alu_ready, lsb_ready, bru_ready  output  1 each  result accepted this cycle.
REQ-010 cdb_valid  output  1  broadcast is valid; registered.
REQ-011 cdb_tag  output  TAG_W  broadcast ROB tag; registered.
REQ-012 cdb_data  output  DATA_W  broadcast data; registered.

Function
REQ-013 Each requester SHALL own a DEPTH-entry FIFO with a write pointer, a read pointer and a count.
REQ-014 x_ready SHALL equal (count_x < DEPTH) & ena & ~rollback, decoded from registered state only.
REQ-015 The FIFO SHALL push an entry when x_valid & x_ready & (x_tag != 0).
REQ-016 A valid result with tag 0 SHALL be acknowledged (ready high) and discarded.
REQ-017 Arbitration SHALL occur each cycle with ena=1 and rollback=0: at most one non-empty FIFO is granted.
REQ-018 Arbitration SHALL be round-robin: search order starts at last_grant+1 mod 3, with ALU=0, LSB=1, BRU=2.
REQ-019 last_grant SHALL update only when a grant is issued.
REQ-020 The granted FIFO SHALL pop its head; cdb_valid/cdb_tag/cdb_data SHALL be loaded with that head on the same edge.
REQ-021 With no grant, cdb_valid SHALL be 0 on the next edge; cdb_tag SHALL be 0; cdb_data SHALL hold its value.
REQ-022 Latency: a result accepted at edge E SHALL be broadcast no earlier than after edge E+1, i.e. no bypass path.
REQ-023 A FIFO popped and pushed in the same cycle SHALL keep its count unchanged.
REQ-024 Push is only possible when count < DEPTH, so overflow SHALL be impossible; pop occurs only on a non-empty FIFO.
REQ-025 Pointers SHALL wrap modulo DEPTH.
REQ-026 Per-requester ordering SHALL be strict FIFO; ordering across requesters is set only by REQ-018.
REQ-027 Starvation bound: a non-empty FIFO SHALL be granted within 3 arbitration cycles.
REQ-028 With ena=0: no push and no pop; pointers, counts and last_grant SHALL hold; cdb_valid SHALL be 0 after the next edge.
REQ-029 With rollback=1 (which has priority over ena): all counts and pointers SHALL clear, cdb_valid and cdb_tag SHALL be 0 after the edge, and the inputs that cycle SHALL be dropped.
REQ-030 rollback SHALL leave last_grant unchanged.

Reset
REQ-031 On an edge with rst=0: all counts and pointers SHALL be 0, last_grant SHALL be 2 (ALU first), cdb_valid=0, cdb_tag=0, cdb_data=0.
REQ-032 Reset SHALL take priority over rollback and ena.
REQ-033 A reset asserted mid-operation SHALL discard all buffered results.
REQ-034 While rst=0, all ready outputs SHALL be 0.

Verification
REQ-035 Single result: after reset, alu_valid=1, tag=3, data=0x11 for one cycle -> alu_ready=1; cdb_valid=1, tag=3, data=0x11 exactly 2 edges later, for one cycle only.
REQ-036 Contention: ALU tag1, LSB tag2 and BRU tag3 presented in the same cycle -> broadcasts occur on 3 consecutive cycles in order tag1, tag2, tag3.
REQ-037 Backpressure: LSB offers tags 4,5,6 on consecutive cycles while the ALU and BRU keep their FIFOs non-empty -> lsb_ready drops when LSB count=2; tags 4,5,6 are each broadcast exactly once and in order.
REQ-038 Stall: both FIFOs loaded, then ena=0 for 3 cycles -> cdb_valid=0 throughout; after ena returns to 1, broadcasts resume with none lost or duplicated.
REQ-039 Flush: entries pending with rollback=1 for one cycle -> cdb_valid=0 after the edge, all FIFOs empty, and no pending tag is ever broadcast.
REQ-040 Tag zero: bru_valid=1 with bru_tag=0 -> bru_ready=1 and no broadcast.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers ALU/LSB/BRU results in per-unit FIFOs and
// round-robins them onto a registered common data bus.
// Ports:
//   clk, rst (sync, active-low), ena (stall when low), rollback (flush)
//   {alu,lsb,bru}_valid/_tag/_data in, {alu,lsb,bru}_ready out
//   cdb_valid/cdb_tag/cdb_data out (registered broadcast)
module cdb_arbiter #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              rollback,
  input  logic              alu_valid,
  input  logic [TAG_W-1:0]  alu_tag,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              lsb_valid,
  input  logic [TAG_W-1:0]  lsb_tag,
  input  logic [DATA_W-1:0] lsb_data,
  output logic              lsb_ready,
  input  logic              bru_valid,
  input  logic [TAG_W-1:0]  bru_tag,
  input  logic [DATA_W-1:0] bru_data,
  output logic              bru_ready,
  output logic              cdb_valid,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_data
);

  localparam int NREQ = 3;
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = $clog2(DEPTH + 1);

  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  // requester ids: ALU=0, LSB=1, BRU=2
  typedef logic [1:0] rid_t;

  logic [NREQ-1:0]   in_vld;
  logic [TAG_W-1:0]  in_tag  [NREQ];
  logic [DATA_W-1:0] in_data [NREQ];

  logic [TAG_W-1:0]  tag_mem_q  [NREQ][DEPTH];
  logic [DATA_W-1:0] data_mem_q [NREQ][DEPTH];

  logic [PW-1:0] wptr_q [NREQ];
  logic [PW-1:0] wptr_d [NREQ];
  logic [PW-1:0] rptr_q [NREQ];
  logic [PW-1:0] rptr_d [NREQ];
  logic [CW-1:0] cnt_q  [NREQ];
  logic [CW-1:0] cnt_d  [NREQ];

  rid_t last_q;
  rid_t last_d;

  logic              cdb_valid_q;
  logic              cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q;
  logic [TAG_W-1:0]  cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q;
  logic [DATA_W-1:0] cdb_data_d;

  logic            active;
  logic [NREQ-1:0] rdy;
  logic [NREQ-1:0] push;
  logic [NREQ-1:0] pop;
  logic            gnt_vld;
  rid_t            gnt_id;

  function automatic logic [PW-1:0] bump(
    input logic [PW-1:0] p
  );
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  assign in_vld     = {bru_valid, lsb_valid, alu_valid};
  assign in_tag[0]  = alu_tag;
  assign in_tag[1]  = lsb_tag;
  assign in_tag[2]  = bru_tag;
  assign in_data[0] = alu_data;
  assign in_data[1] = lsb_data;
  assign in_data[2] = bru_data;

  // arbitration and acceptance both need a live, unflushed cycle
  assign active = rst & ena & ~rollback;

  // ready looks only at registered counts; tag 0 is
  // acknowledged but never stored
  always_comb begin
    rdy  = '0;
    push = '0;
    for (int i = 0; i < NREQ; i++) begin
      rdy[i]  = active & (cnt_q[i] < CNT_FULL);
      push[i] = in_vld[i] & rdy[i]
              & (in_tag[i] != '0);
    end
  end

  // round-robin search starting after the last grant;
  // registered counts only, so no same-cycle bypass
  always_comb begin
    int   s;
    rid_t id;
    s       = 0;
    id      = '0;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      s = int'(last_q) + k;
      if (s >= NREQ) s = s - NREQ;
      id = rid_t'(s);
      if (active && !gnt_vld
          && cnt_q[id] != '0) begin
        gnt_vld = 1'b1;
        gnt_id  = id;
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < NREQ; i++) begin
      pop[i] = gnt_vld & (gnt_id == rid_t'(i));
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      wptr_d[i] = wptr_q[i];
      rptr_d[i] = rptr_q[i];
      cnt_d[i]  = cnt_q[i];
      if (rollback) begin
        wptr_d[i] = '0;
        rptr_d[i] = '0;
        cnt_d[i]  = '0;
      end else begin
        if (push[i]) wptr_d[i] = bump(wptr_q[i]);
        if (pop[i])  rptr_d[i] = bump(rptr_q[i]);
        if (push[i] && !pop[i])
          cnt_d[i] = cnt_q[i] + CW'(1);
        else if (!push[i] && pop[i])
          cnt_d[i] = cnt_q[i] - CW'(1);
      end
    end
  end

  // with no grant the bus drops valid and tag but data holds
  always_comb begin
    cdb_valid_d = gnt_vld;
    cdb_tag_d   = '0;
    cdb_data_d  = cdb_data_q;
    last_d      = last_q;
    if (gnt_vld) begin
      cdb_tag_d  = tag_mem_q[gnt_id][rptr_q[gnt_id]];
      cdb_data_d = data_mem_q[gnt_id][rptr_q[gnt_id]];
      last_d     = gnt_id;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREQ; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      last_q      <= 2'd2;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      last_q      <= last_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
    end
  end

  // storage needs no reset; push is already gated by rst
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (push[i]) begin
        tag_mem_q[i][wptr_q[i]]  <= in_tag[i];
        data_mem_q[i][wptr_q[i]] <= in_data[i];
      end
    end
  end

  assign alu_ready = rdy[0];
  assign lsb_ready = rdy[1];
  assign bru_ready = rdy[2];

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: queue-based reference model plus scoreboard
// monitor for the CDB arbiter.
module tb_cdb_arbiter;

  localparam int DW = 32;
  localparam int TW = 4;
  localparam int DP = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          ena;
  logic          rollback;
  logic          alu_valid;
  logic [TW-1:0] alu_tag;
  logic [DW-1:0] alu_data;
  logic          alu_ready;
  logic          lsb_valid;
  logic [TW-1:0] lsb_tag;
  logic [DW-1:0] lsb_data;
  logic          lsb_ready;
  logic          bru_valid;
  logic [TW-1:0] bru_tag;
  logic [DW-1:0] bru_data;
  logic          bru_ready;
  logic          cdb_valid;
  logic [TW-1:0] cdb_tag;
  logic [DW-1:0] cdb_data;

  cdb_arbiter #(
    .DATA_W(DW),
    .TAG_W (TW),
    .DEPTH (DP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .rollback (rollback),
    .alu_valid(alu_valid),
    .alu_tag  (alu_tag),
    .alu_data (alu_data),
    .alu_ready(alu_ready),
    .lsb_valid(lsb_valid),
    .lsb_tag  (lsb_tag),
    .lsb_data (lsb_data),
    .lsb_ready(lsb_ready),
    .bru_valid(bru_valid),
    .bru_tag  (bru_tag),
    .bru_data (bru_data),
    .bru_ready(bru_ready),
    .cdb_valid(cdb_valid),
    .cdb_tag  (cdb_tag),
    .cdb_data (cdb_data)
  );

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } ent_t;

  typedef struct packed {
    int            cyc;
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } exp_t;

  ent_t mq [3][$];
  exp_t expq [$];

  int            lg      = 2;
  int            cyc     = 0;
  int            rst_cyc = -1;
  bit            mon_en  = 1'b0;
  logic [DW-1:0] hold    = '0;
  int            nchk    = 0;
  int            nerr    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  // reference: one queue per unit, rotating pointer lg
  task automatic model_step(output logic [2:0] er);
    logic [2:0]    v;
    logic [TW-1:0] t [3];
    logic [DW-1:0] d [3];
    bit            done;
    int            r;
    ent_t          e;
    v    = {bru_valid, lsb_valid, alu_valid};
    t[0] = alu_tag;  t[1] = lsb_tag;  t[2] = bru_tag;
    d[0] = alu_data; d[1] = lsb_data; d[2] = bru_data;
    er   = 3'b000;
    done = 1'b0;
    if (!rst) begin
      for (int x = 0; x < 3; x++) mq[x].delete();
      lg      = 2;
      rst_cyc = cyc + 1;
    end else if (rollback) begin
      for (int x = 0; x < 3; x++) mq[x].delete();
    end else if (ena) begin
      for (int x = 0; x < 3; x++)
        er[x] = (mq[x].size() < DP);
      for (int k = 1; k <= 3; k++) begin
        r = (lg + k) % 3;
        if (!done && mq[r].size() > 0) begin
          e = mq[r].pop_front();
          expq.push_back('{cyc + 1, e.tag, e.data});
          lg   = r;
          done = 1'b1;
        end
      end
      for (int x = 0; x < 3; x++)
        if (v[x] && er[x] && t[x] != '0)
          mq[x].push_back('{t[x], d[x]});
    end
  endtask

  task automatic tick(output logic [2:0] er);
    #1;
    model_step(er);
    chk("alu_ready", 64'(alu_ready), 64'(er[0]));
    chk("lsb_ready", 64'(lsb_ready), 64'(er[1]));
    chk("bru_ready", 64'(bru_ready), 64'(er[2]));
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int x, input logic v,
                        input logic [TW-1:0] t,
                        input logic [DW-1:0] d);
    case (x)
      0: begin alu_valid = v; alu_tag = t; alu_data = d; end
      1: begin lsb_valid = v; lsb_tag = t; lsb_data = d; end
      default: begin
        bru_valid = v; bru_tag = t; bru_data = d;
      end
    endcase
  endtask

  task automatic clr_in();
    for (int x = 0; x < 3; x++) set_in(x, 1'b0, '0, '0);
  endtask

  task automatic idle(input int n);
    logic [2:0] er;
    clr_in();
    for (int i = 0; i < n; i++) tick(er);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (cyc == rst_cyc) hold = '0;
      if (cdb_valid) begin
        if (expq.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL cdb_unexpected: got tag %0d, none expected cycle %0d",
                   cdb_tag, cyc);
        end else begin
          e = expq.pop_front();
          chk("cdb_cycle", 64'(cyc), 64'(e.cyc));
          chk("cdb_tag", 64'(cdb_tag), 64'(e.tag));
          chk("cdb_data", 64'(cdb_data), 64'(e.data));
          hold = e.data;
        end
      end else begin
        if (expq.size() > 0 && expq[0].cyc <= cyc) begin
          void'(expq.pop_front());
          chk("cdb_valid_missing", 64'(cdb_valid), 64'(1));
        end
        chk("cdb_tag_idle", 64'(cdb_tag), 64'(0));
        chk("cdb_data_hold", 64'(cdb_data), 64'(hold));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] er;
    int         lt;
    rst      = 1'b0;
    ena      = 1'b0;
    rollback = 1'b0;
    clr_in();
    @(posedge clk);
    #1;
    tick(er);
    tick(er);
    mon_en = 1'b1;

    // single result
    rst = 1'b1;
    ena = 1'b1;
    set_in(0, 1'b1, 4'd3, 32'h11);
    tick(er);
    idle(5);

    // contention right after reset: ALU, LSB, BRU order
    rst = 1'b0;
    tick(er);
    rst = 1'b1;
    set_in(0, 1'b1, 4'd1, 32'h101);
    set_in(1, 1'b1, 4'd2, 32'h202);
    set_in(2, 1'b1, 4'd3, 32'h303);
    tick(er);
    idle(6);

    // backpressure on LSB while ALU and BRU stay busy
    lt = 4;
    for (int c = 0; c < 18; c++) begin
      set_in(0, 1'b1, 4'(7 + c % 4), 32'hA00 + c);
      set_in(2, 1'b1, 4'(11 + c % 4), 32'hB00 + c);
      if (lt <= 6)
        set_in(1, 1'b1, 4'(lt), 32'h400 + lt);
      else
        set_in(1, 1'b0, '0, '0);
      tick(er);
      if (er[1] && lt <= 6) lt++;
    end
    idle(10);

    // stall with loaded FIFOs
    for (int c = 0; c < 2; c++) begin
      set_in(0, 1'b1, 4'(9 + c), 32'hC00 + c);
      set_in(2, 1'b1, 4'(12 + c), 32'hD00 + c);
      tick(er);
    end
    clr_in();
    ena = 1'b0;
    idle(3);
    ena = 1'b1;
    idle(8);

    // flush with pending entries and live offers
    for (int c = 0; c < 2; c++) begin
      set_in(0, 1'b1, 4'(1 + c), 32'hE00 + c);
      set_in(1, 1'b1, 4'(3 + c), 32'hE10 + c);
      tick(er);
    end
    set_in(2, 1'b1, 4'd5, 32'hE20);
    rollback = 1'b1;
    tick(er);
    rollback = 1'b0;
    idle(6);

    // tag zero is acknowledged and dropped
    set_in(2, 1'b1, 4'd0, 32'hDEAD);
    tick(er);
    idle(4);

    // reset mid-operation discards buffered results
    for (int c = 0; c < 2; c++) begin
      set_in(0, 1'b1, 4'(6 + c), 32'hF00 + c);
      set_in(1, 1'b1, 4'(8 + c), 32'hF10 + c);
      tick(er);
    end
    clr_in();
    rst = 1'b0;
    tick(er);
    rst = 1'b1;
    idle(6);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(0, 199) != 0);
      ena      = ($urandom_range(0, 9) != 0);
      rollback = ($urandom_range(0, 39) == 0);
      for (int x = 0; x < 3; x++)
        set_in(x, ($urandom_range(0, 2) != 0),
               4'($urandom_range(0, 15)), $urandom);
      tick(er);
    end
    rst      = 1'b1;
    ena      = 1'b1;
    rollback = 1'b0;
    idle(12);

    chk("expq_drained", 64'(expq.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule
